// File: rtl/lsu_queue.sv
// lsu_queue: in-order load/store queue feeding a single-outstanding memory port.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module lsu_queue #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_size,
  input  logic              mem_ok,
  input  logic [31:0]       mem_rdata,
  output logic              res_valid,
  output logic [TAG_W-1:0]  res_tag,
  output logic [31:0]       res_data,
  output logic              res_misalign,
  output logic              busy_out,
  input  logic              rollback_in
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic              live;
    logic              store;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  entry_t           queue_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  state_t           state_q;
  logic             waitLoad_q, waitKilled_q, waitUns_q;
  logic [1:0]       waitSize_q;
  logic [TAG_W-1:0] waitTag_q;

  entry_t headEntry;
  logic   push, pop, headLive, issue, trap;

  function automatic logic [2:0] sizeBytes(input logic [1:0] s);
    case (s)
      2'd0:    sizeBytes = 3'd1;
      2'd1:    sizeBytes = 3'd2;
      default: sizeBytes = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] s,
                                         input logic uns);
    case (s)
      2'd0:    extend = {{24{d[7] & ~uns}}, d[7:0]};
      2'd1:    extend = {{16{d[15] & ~uns}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  assign headEntry = queue_q[head_q];
  assign req_ready = count_q < FULL_CNT;
  assign push      = req_valid & req_ready & rdy_in;
  assign pop       = rdy_in & (state_q == S_IDLE) & (count_q != '0);
  // A rollback in the same cycle also kills a load that is just reaching the head.
  assign headLive  = headEntry.live & ~(rollback_in & ~headEntry.store);
  assign issue     = pop & headLive;
  assign busy_out  = (count_q != '0) | (state_q != S_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((headEntry.size == 2'd1) & headEntry.addr[0]) |
                      (headEntry.size[1] & (headEntry.addr[1:0] != 2'b00));
  assign trap = issue & misaligned;
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(push);
    count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) queue_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      if (rollback_in) begin
        for (int i = 0; i < DEPTH; i++)
          if (!queue_q[i].store) queue_q[i].live <= 1'b0;
      end
      if (push) begin
        queue_q[tail_q] <= '{live: ~(rollback_in & ~req_store), store: req_store,
                             size: req_size, uns: req_unsigned, addr: req_addr,
                             data: req_data, tag: req_tag};
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      mem_en       <= 1'b0;
      mem_rw       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_size     <= 3'd4;
      res_valid    <= 1'b0;
      res_misalign <= 1'b0;
      res_tag      <= '0;
      res_data     <= '0;
      waitLoad_q   <= 1'b0;
      waitKilled_q <= 1'b0;
      waitUns_q    <= 1'b0;
      waitSize_q   <= '0;
      waitTag_q    <= '0;
    end else if (rdy_in) begin
      mem_en       <= 1'b0;
      res_valid    <= 1'b0;
      res_misalign <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (trap) begin
            res_valid    <= 1'b1;
            res_misalign <= 1'b1;
            res_tag      <= headEntry.tag;
            res_data     <= '0;
          end else if (issue) begin
            mem_en       <= 1'b1;
            mem_rw       <= headEntry.store;
            mem_addr     <= headEntry.addr;
            mem_wdata    <= headEntry.data;
            mem_size     <= sizeBytes(headEntry.size);
            waitLoad_q   <= ~headEntry.store;
            waitKilled_q <= 1'b0;
            waitUns_q    <= headEntry.uns;
            waitSize_q   <= headEntry.size;
            waitTag_q    <= headEntry.tag;
            state_q      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rollback_in) waitKilled_q <= 1'b1;
          if (mem_ok) begin
            if (waitLoad_q & ~waitKilled_q & ~rollback_in) begin
              res_valid <= 1'b1;
              res_tag   <= waitTag_q;
              res_data  <= extend(mem_rdata, waitSize_q, waitUns_q);
            end
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
